// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types, BCD constants and width helper for the sequential binary-to-BCD converter.
package bin2bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/bin2bcd_if.sv
// bin2bcd_if: valid/ready request and result bus of the binary-to-BCD converter.
interface bin2bcd_if #(parameter int BIN_W = 8, parameter int DIGITS = 3);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic [DIGITS-1:0]     digit_en;
   logic                  overflow;
   logic                  busy;
   modport master (output in_valid, bin_in, out_ready,
                   input  in_ready, out_valid, bcd_out, digit_en, overflow, busy);
   modport slave  (input  in_valid, bin_in, out_ready,
                   output in_ready, out_valid, bcd_out, digit_en, overflow, busy);
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: add-3 correction of one BCD digit ahead of a left shift.
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d_i,
   output logic [BCD_DIGIT_W-1:0] d_o
);
   assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift-and-add-3 binary-to-BCD converter, one input bit per clock, with
// overflow saturation and leading-zero blanking for the display digit enables.
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic clk,
   input  logic rst_n,
   bin2bcd_if.slave bus
);
   localparam int ACC_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = clog2(BIN_W + 1);

   state_t            state_q;
   logic [BIN_W-1:0]  sh_q, sh_d;
   logic [ACC_W-1:0]  acc_q, adj, acc_d, bcd_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DIGITS-1:0] en_d, en_q;
   logic              ovf_q, ovf_d, ovfo_q, accept;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (.d_i(acc_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]), .d_o(adj[i*BCD_DIGIT_W +: BCD_DIGIT_W]));
   end

   // The bit leaving the top digit means the value no longer fits; it is kept sticky.
   assign {acc_d, sh_d} = {adj[ACC_W-2:0], sh_q, 1'b0};
   assign ovf_d         = ovf_q | adj[ACC_W-1];

   always_comb begin
      en_d = '0;
      for (int i = 0; i < DIGITS; i++) en_d[i] = (i == 0) || (|(acc_d >> (BCD_DIGIT_W * i)));
   end

   assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.out_valid = state_q == DONE;
   assign bus.busy      = state_q == SHIFT;
   assign bus.bcd_out   = bcd_q;
   assign bus.digit_en  = en_q;
   assign bus.overflow  = ovfo_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         en_q    <= '0;
         ovfo_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  state_q <= SHIFT;
                  sh_q    <= bus.bin_in;
                  acc_q   <= '0;
                  ovf_q   <= 1'b0;
                  cnt_q   <= CNT_W'(BIN_W);
               end else if (state_q == DONE && bus.out_ready) begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               sh_q  <= sh_d;
               acc_q <= acc_d;
               ovf_q <= ovf_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  bcd_q   <= ovf_d ? {DIGITS{BCD_NINE}} : acc_d;
                  en_q    <= ovf_d ? '1 : en_d;
                  ovfo_q  <= ovf_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized and directed checks of bin2bcd_seq in three width/digit configurations
// against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bin2bcd_if #(.BIN_W(8), .DIGITS(3)) a ();
   bin2bcd_if #(.BIN_W(7), .DIGITS(2)) b ();
   bin2bcd_if #(.BIN_W(6), .DIGITS(2)) c ();

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
   bin2bcd_seq #(.BIN_W(7), .DIGITS(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));
   bin2bcd_seq #(.BIN_W(6), .DIGITS(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(c));

   function automatic logic [11:0] m_bcd(input int v, input int d);
      logic [11:0] r = '0;
      int p = 1;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = (v >= 10**d) ? 4'd9 : 4'((v / p) % 10);
         p *= 10;
      end
      return r;
   endfunction

   function automatic logic [2:0] m_en(input int v, input int d);
      logic [2:0] r = '0;
      int p = 1;
      for (int i = 0; i < d; i++) begin
         r[i] = (i == 0) || (v >= p) || (v >= 10**d);
         p *= 10;
      end
      return r;
   endfunction

   task automatic conv_a(input logic [7:0] v, output logic [11:0] bcd, output logic [2:0] en,
                         output logic ovf, output int lat);
      int w = 0;
      a.in_valid = 1'b1;
      a.bin_in   = v;
      while (!a.in_ready && w < 50) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      a.in_valid = 1'b0;
      a.bin_in   = 8'($urandom);
      lat = 0;
      while (!a.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      bcd = a.bcd_out;
      en  = a.digit_en;
      ovf = a.overflow;
      a.out_ready = 1'b1;
      @(posedge clk); #1;
      a.out_ready = 1'b0;
   endtask

   task automatic conv_b(input logic [6:0] v, output logic [7:0] bcd, output logic [1:0] en,
                         output logic ovf, output int lat);
      int w = 0;
      b.in_valid = 1'b1;
      b.bin_in   = v;
      while (!b.in_ready && w < 50) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      b.in_valid = 1'b0;
      b.bin_in   = 7'($urandom);
      lat = 0;
      while (!b.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      bcd = b.bcd_out;
      en  = b.digit_en;
      ovf = b.overflow;
      b.out_ready = 1'b1;
      @(posedge clk); #1;
      b.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a.in_ready); end
      checks++; if (a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a.out_valid); end
      checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a.busy); end
      checks++; if (a.bcd_out !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h exp 000", a.bcd_out); end
      checks++; if (a.digit_en !== 3'b000) begin errors++; $display("FAIL reset_digit_en got %b exp 000", a.digit_en); end
      checks++; if (a.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", a.overflow); end
      checks++; if (b.bcd_out !== 8'h00 || b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b got %h/%b exp 00/0", b.bcd_out, b.out_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed_a();
      int vals[3] = '{0, 255, 47};
      logic [11:0] bcd;
      logic [2:0] en;
      logic ovf;
      int lat;
      foreach (vals[k]) begin
         conv_a(8'(vals[k]), bcd, en, ovf, lat);
         checks++; if (bcd !== m_bcd(vals[k], 3)) begin errors++; $display("FAIL dir_bcd v=%0d got %h exp %h", vals[k], bcd, m_bcd(vals[k], 3)); end
         checks++; if (en !== m_en(vals[k], 3)) begin errors++; $display("FAIL dir_en v=%0d got %b exp %b", vals[k], en, m_en(vals[k], 3)); end
         checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL dir_ovf v=%0d got %b exp 0", vals[k], ovf); end
         checks++; if (lat != 8) begin errors++; $display("FAIL dir_latency v=%0d got %0d exp 8", vals[k], lat); end
      end
   endtask

   task automatic test_random_a();
      logic [11:0] bcd;
      logic [2:0] en;
      logic ovf;
      int lat, v;
      for (int k = 0; k < 25; k++) begin
         v = $urandom_range(0, 255);
         conv_a(8'(v), bcd, en, ovf, lat);
         checks++;
         if (bcd !== m_bcd(v, 3) || en !== m_en(v, 3) || ovf !== 1'b0 || lat != 8) begin
            errors++;
            $display("FAIL rand_a v=%0d got %h/%b/%b/%0d exp %h/%b/0/8", v, bcd, en, ovf, lat, m_bcd(v, 3), m_en(v, 3));
         end
      end
   endtask

   task automatic test_overflow_b();
      int vals[16] = '{99, 100, 127, 0, 9, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      logic [11:0] exp_b;
      logic [2:0] exp_e;
      logic [7:0] bcd;
      logic [1:0] en;
      logic ovf;
      int lat;
      for (int k = 6; k < 16; k++) vals[k] = $urandom_range(0, 127);
      foreach (vals[k]) begin
         conv_b(7'(vals[k]), bcd, en, ovf, lat);
         exp_b = m_bcd(vals[k], 2);
         exp_e = m_en(vals[k], 2);
         checks++; if (bcd !== exp_b[7:0]) begin errors++; $display("FAIL ovf_bcd v=%0d got %h exp %h", vals[k], bcd, exp_b[7:0]); end
         checks++; if (en !== exp_e[1:0]) begin errors++; $display("FAIL ovf_en v=%0d got %b exp %b", vals[k], en, exp_e[1:0]); end
         checks++; if (ovf !== (vals[k] >= 100)) begin errors++; $display("FAIL ovf_flag v=%0d got %b exp %b", vals[k], ovf, vals[k] >= 100); end
         checks++; if (lat != 7) begin errors++; $display("FAIL ovf_latency v=%0d got %0d exp 7", vals[k], lat); end
      end
   endtask

   task automatic test_back_pressure();
      int lat = 0;
      a.in_valid = 1'b1;
      a.bin_in   = 8'd123;
      a.out_ready = 1'b0;
      @(posedge clk); #1;
      a.in_valid = 1'b0;
      while (!a.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (a.out_valid !== 1'b1 || a.bcd_out !== 12'h123 || a.digit_en !== 3'b111 || a.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold k=%0d got v=%b bcd=%h en=%b rdy=%b exp 1/123/111/0", k, a.out_valid, a.bcd_out, a.digit_en, a.in_ready);
         end
         @(posedge clk); #1;
      end
      a.out_ready = 1'b1;
      a.in_valid  = 1'b1;
      a.bin_in    = 8'd9;
      #1;
      checks++; if (a.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_same_cycle got %b exp 1", a.in_ready); end
      @(posedge clk); #1;
      checks++; if (a.busy !== 1'b1 || a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_reaccept got busy=%b valid=%b exp 1/0", a.busy, a.out_valid); end
      a.in_valid  = 1'b0;
      a.out_ready = 1'b0;
      a.bin_in    = 8'($urandom);
      lat = 0;
      while (!a.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != 8) begin errors++; $display("FAIL bp_latency got %0d exp 8", lat); end
      checks++; if (a.bcd_out !== 12'h009 || a.digit_en !== 3'b001) begin errors++; $display("FAIL bp_result got %h/%b exp 009/001", a.bcd_out, a.digit_en); end
      a.out_ready = 1'b1;
      @(posedge clk); #1;
      a.out_ready = 1'b0;
      checks++; if (a.out_valid !== 1'b0 || a.bcd_out !== 12'h009) begin errors++; $display("FAIL bp_after got %b/%h exp 0/009", a.out_valid, a.bcd_out); end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      logic [11:0] bcd;
      logic [2:0] en;
      logic ovf;
      int lat;
      a.in_valid = 1'b1;
      a.bin_in   = 8'd200;
      @(posedge clk); #1;
      a.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (a.busy !== 1'b0 || a.in_ready !== 1'b1 || a.out_valid !== 1'b0 || a.bcd_out !== 12'h000 || a.digit_en !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset got busy=%b rdy=%b v=%b bcd=%h en=%b exp 0/1/0/000/000", a.busy, a.in_ready, a.out_valid, a.bcd_out, a.digit_en);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (a.out_valid) seen++;
         @(posedge clk); #1;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_result got %0d valid cycles exp 0", seen); end
      conv_a(8'd13, bcd, en, ovf, lat);
      checks++; if (bcd !== 12'h013 || en !== 3'b011 || lat != 8) begin errors++; $display("FAIL mid_next got %h/%b/%0d exp 013/011/8", bcd, en, lat); end
   endtask

   task automatic test_exhaustive_c();
      int q[$];
      int nxt = 0, got = 0, cyc = 0, e;
      logic [11:0] exp_b;
      logic [2:0] exp_e;
      c.out_ready = 1'b1;
      c.in_valid  = 1'b1;
      c.bin_in    = 6'd0;
      while (got < 64 && cyc < 2000) begin
         if (c.out_valid) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL exh_spurious got valid with nothing pending exp none");
            end else begin
               e = q.pop_front();
               exp_b = m_bcd(e, 2);
               exp_e = m_en(e, 2);
               if (c.bcd_out !== exp_b[7:0] || c.digit_en !== exp_e[1:0] || c.overflow !== 1'b0) begin
                  errors++;
                  $display("FAIL exh v=%0d got %h/%b/%b exp %h/%b/0", e, c.bcd_out, c.digit_en, c.overflow, exp_b[7:0], exp_e[1:0]);
               end
            end
            got++;
         end
         if (c.in_valid && c.in_ready) begin q.push_back(nxt); nxt++; end
         @(posedge clk); #1;
         cyc++;
         if (nxt < 64) c.bin_in = 6'(nxt);
         else c.in_valid = 1'b0;
      end
      checks++; if (got != 64) begin errors++; $display("FAIL exh_count got %0d exp 64", got); end
      c.out_ready = 1'b0;
   endtask

   initial begin
      a.in_valid = 1'b0; a.bin_in = '0; a.out_ready = 1'b0;
      b.in_valid = 1'b0; b.bin_in = '0; b.out_ready = 1'b0;
      c.in_valid = 1'b0; c.bin_in = '0; c.out_ready = 1'b0;
      test_reset();
      test_directed_a();
      test_random_a();
      test_overflow_b();
      test_back_pressure();
      test_reset_mid();
      test_exhaustive_c();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end
endmodule
